// File: rtl/sr_t.sv
// Clocked, enable-gated set/reset bit with a true/complement output pair.
// S=R=1 is latched as a flagged forbidden state rather than left undefined.
module sr_t (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic S,
    input  logic R,
    output logic Q,
    output logic n_Q,
    output logic illegal
);

    logic q_state;
    logic forb;
    logic q_next;
    logic forb_next;

    // S/R are only looked at inside the en branch, so unknowns on them cannot leak into state while gated off.
    always_comb begin
        q_next    = q_state;
        forb_next = forb;
        if (en) begin
            case ({S, R})
                2'b10:   begin q_next = 1'b1;    forb_next = 1'b0; end
                2'b01:   begin q_next = 1'b0;    forb_next = 1'b0; end
                2'b11:   begin q_next = 1'b0;    forb_next = 1'b1; end
                default: begin q_next = q_state; forb_next = 1'b0; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_state <= 1'b0;
            forb    <= 1'b0;
        end else begin
            q_state <= q_next;
            forb    <= forb_next;
        end
    end

    // Forbidden state drives both rails low, like a NOR latch with both inputs high.
    assign Q       = q_state;
    assign n_Q     = ~q_state & ~forb;
    assign illegal = forb;

endmodule

// File: tb/tb_sr_t.sv
// Self-checking bench for sr_t: directed test-plan steps through a scoreboard
// queue, then random en/S/R/rst_n traffic checked against a behavioural model.
module tb_sr_t;

    logic clk;
    logic rst_n;
    logic en;
    logic S;
    logic R;
    logic Q;
    logic n_Q;
    logic illegal;

    int tests_run = 0;
    int tests_failed = 0;

    logic [2:0] sb[$];
    logic m_q;
    logic m_forb;

    sr_t dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .S       (S),
        .R       (R),
        .Q       (Q),
        .n_Q     (n_Q),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0] outs();
        return {Q, n_Q, illegal};
    endfunction

    // Drive one input vector, push the expected {Q,n_Q,illegal}, clock it, compare.
    task automatic step(input logic e, input logic s, input logic r,
                        input logic [2:0] exp, input string tag);
        logic [2:0] obs;
        en = e; S = s; R = r;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        obs = outs();
        check(tag, obs, sb.pop_front());
        check({tag, "_nox"}, {2'b00, $isunknown(obs)}, 3'b000);
        $display("[TB] %s en=%b S=%b R=%b -> Q=%b n_Q=%b illegal=%b", tag, e, s, r, obs[2], obs[1], obs[0]);
    endtask

    task automatic model_edge(input logic e, input logic s, input logic r);
        if (e) begin
            if (s && r)       begin m_q = 1'b0; m_forb = 1'b1; end
            else if (s)       begin m_q = 1'b1; m_forb = 1'b0; end
            else if (r)       begin m_q = 1'b0; m_forb = 1'b0; end
            else              begin m_forb = 1'b0; end
        end
    endtask

    initial begin
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] exp;
        rst_n = 1'b0; en = 1'b1; S = 1'b1; R = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", outs(), 3'b010);
        end
        rst_n = 1'b1;
        step(1, 1, 0, 3'b100, "reset_release");

        step(1, 1, 0, 3'b100, "set");
        step(1, 0, 0, 3'b100, "set_hold");
        step(0, 1'bx, 1'bx, 3'b100, "set_gated");
        step(1, 0, 1, 3'b010, "clear");
        step(1, 0, 0, 3'b010, "clear_hold");
        step(0, 1'bx, 1'bx, 3'b010, "clear_gated");
        step(1, 1, 0, 3'b100, "pre_forb_set");
        step(1, 1, 1, 3'b001, "forbidden");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 3'b001, "forb_gated");
        step(1, 0, 0, 3'b010, "forb_hold_recover");
        step(1, 1, 1, 3'b001, "forbidden2");
        step(1, 1, 0, 3'b100, "forb_set_recover");

        // Asynchronous reset dropped between edges
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; S = 1'b1; R = 1'b0;
        #1;
        check("async_reset", outs(), 3'b010);
        step(1, 1, 0, 3'b010, "reset_held");
        step(1, 1, 0, 3'b010, "reset_held");
        rst_n = 1'b1;
        step(1, 1, 0, 3'b100, "reset_after");

        m_q = 1'b1; m_forb = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            rst_n = ($urandom_range(19) != 0);
            en    = $urandom_range(1);
            S     = $urandom_range(1);
            R     = $urandom_range(1);
            if (!rst_n) begin m_q = 1'b0; m_forb = 1'b0; end
            exp = {m_q, ~m_q & ~m_forb, m_forb};
            #1;
            a = outs();
            check("rnd_pre", a, exp);
            @(negedge clk);
            b = outs();
            check("rnd_stable", b, a);
            if (rst_n) model_edge(en, S, R);
            sb.push_back({m_q, ~m_q & ~m_forb, m_forb});
            @(posedge clk);
            #1;
            a = outs();
            check("rnd_edge", a, sb.pop_front());
            check("inv_not_both_high", {2'b00, a[2] & a[1]}, 3'b000);
            check("inv_both_low_illegal", {2'b00, ~a[2] & ~a[1] & ~a[0]}, 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
